// File: rtl/io_block_registered.sv
// -----------------------------------------------------------------------------
// io_block_registered
//
// Data I/O block sitting between a W-bit routing track bus and a set of
// WW-bit external ports.  The block is configured through a serial scan chain:
// bits are shifted into a shadow register and copied into the active
// configuration only on cfg_load.  Shifting never disturbs the active
// configuration, so the datapath keeps running while a new configuration is
// being streamed in.
//
// Every external port can run registered (one cycle of latency) or bypassed
// (combinational).  The track side uses separate value and enable buses
// instead of a tri-state bus.  If two input ports are enabled onto the same
// track, a sticky conflict flag is raised.
//
// Active configuration layout (CONN_BITS = W*(EXTDATAIN+EXTDATAOUT)):
//   [j + i*W]                   input port i, bit j%WW  -> track j
//   [j + i*W + EXTDATAIN*W]     track j -> output port i, bit j%WW
//   [CONN_BITS + i]             input port i registered (1) / bypass (0)
//   [CONN_BITS + EXTDATAIN + i] output port i registered (1) / bypass (0)
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-high reset
//   cfg_en           shift the configuration chain by one bit
//   cfg_in           serial configuration data in (LSB first)
//   cfg_load         copy the shadow chain into the active configuration
//   cfg_out          serial data out (shadow[0]) for daisy-chaining
//   track_in         value currently present on the routing tracks
//   track_out        value this block drives onto the tracks
//   track_oe         per-track drive enable
//   external_input   input ports, port i = bits [i*WW +: WW]
//   external_output  output ports, port i = bits [i*WW +: WW]
//   ext_oe           per-bit enable for external_output
//   conflict         sticky flag: some track had more than one enabled driver
// -----------------------------------------------------------------------------
module io_block_registered #(
    parameter int W          = 6,
    parameter int WW         = 3,
    parameter int EXTDATAIN  = 2,
    parameter int EXTDATAOUT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_en,
    input  logic                       cfg_in,
    input  logic                       cfg_load,
    output logic                       cfg_out,
    input  logic [W-1:0]               track_in,
    output logic [W-1:0]               track_out,
    output logic [W-1:0]               track_oe,
    input  logic [WW*EXTDATAIN-1:0]    external_input,
    output logic [WW*EXTDATAOUT-1:0]   external_output,
    output logic [WW*EXTDATAOUT-1:0]   ext_oe,
    output logic                       conflict
);

    localparam int CONN_BITS = W * (EXTDATAIN + EXTDATAOUT);
    localparam int CFG_BITS  = CONN_BITS + EXTDATAIN + EXTDATAOUT;
    localparam int MODE_IN   = CONN_BITS;
    localparam int MODE_OUT  = CONN_BITS + EXTDATAIN;
    localparam int OUT_BASE  = EXTDATAIN * W;
    // Number of tracks that map onto any given port bit position.
    localparam int TRK_PER_BIT = W / WW;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CFG_BITS-1:0]      shadow_reg;
    logic [CFG_BITS-1:0]      active_reg;
    logic [WW*EXTDATAIN-1:0]  in_reg;
    logic [WW*EXTDATAOUT-1:0] out_reg;
    logic                     conflict_reg;

    // Combinational datapath nets
    logic [WW*EXTDATAIN-1:0]  src_bus;      // selected source per input port
    logic [W-1:0]             multi_drv;    // track has >= 2 enabled drivers
    logic [WW*EXTDATAOUT-1:0] out_v_next;   // OR-ed track value per output bit
    logic [WW*EXTDATAOUT-1:0] out_oe_next;  // OR-ed enables per output bit

    // -------------------------------------------------------------------------
    // Configuration chain.  cfg_load samples the pre-shift shadow value even
    // when cfg_en is asserted in the same cycle, since both use shadow_reg
    // as it stood before the edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg <= '0;
            active_reg <= '0;
        end else begin
            if (cfg_en) begin
                shadow_reg <= {cfg_in, shadow_reg[CFG_BITS-1:1]};
            end
            if (cfg_load) begin
                active_reg <= shadow_reg;
            end
        end
    end

    assign cfg_out = shadow_reg[0];

    // -------------------------------------------------------------------------
    // Port registers sample every cycle regardless of mode, so a mode switch
    // to registered immediately shows the last sampled value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_reg  <= '0;
            out_reg <= '0;
        end else begin
            in_reg  <= external_input;
            out_reg <= out_v_next;
        end
    end

    // -------------------------------------------------------------------------
    // Conflict flag: cleared by a load (the new configuration is judged from
    // the following edge on), otherwise set whenever the active configuration
    // drives a track from two or more input ports.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_reg <= 1'b0;
        end else if (cfg_load) begin
            conflict_reg <= 1'b0;
        end else if (|multi_drv) begin
            conflict_reg <= 1'b1;
        end
    end

    assign conflict = conflict_reg;

    // -------------------------------------------------------------------------
    // Input source selection per port: registered copy or live input.
    // -------------------------------------------------------------------------
    genvar gi, gp, gb, gk;
    generate
        for (gi = 0; gi < EXTDATAIN; gi++) begin : g_in_src
            assign src_bus[gi*WW +: WW] = active_reg[MODE_IN + gi]
                                        ? in_reg[gi*WW +: WW]
                                        : external_input[gi*WW +: WW];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Track drivers.  Track gi takes bit gi%WW of each enabled input port.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < W; gi++) begin : g_track
            logic [EXTDATAIN-1:0] drv_en;
            logic [EXTDATAIN-1:0] drv_v;
            for (gp = 0; gp < EXTDATAIN; gp++) begin : g_drv
                assign drv_en[gp] = active_reg[gi + gp*W];
                assign drv_v[gp]  = drv_en[gp] & src_bus[gp*WW + (gi % WW)];
            end
            assign track_oe[gi]  = |drv_en;
            assign track_out[gi] = |drv_v;
            // Clearing the lowest set bit leaves something only if two or
            // more drivers are enabled.
            assign multi_drv[gi] = |(drv_en & (drv_en - 1'b1));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output ports.  Bit gb of port gi collects every track j with j%WW == gb,
    // i.e. tracks gk*WW + gb.  Multiple enabled tracks simply OR together.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < EXTDATAOUT; gi++) begin : g_out_port
            for (gb = 0; gb < WW; gb++) begin : g_out_bit
                logic [TRK_PER_BIT-1:0] term_en;
                logic [TRK_PER_BIT-1:0] term_v;
                for (gk = 0; gk < TRK_PER_BIT; gk++) begin : g_term
                    assign term_en[gk] = active_reg[OUT_BASE + gi*W + gk*WW + gb];
                    assign term_v[gk]  = term_en[gk] & track_in[gk*WW + gb];
                end
                assign out_v_next[gi*WW + gb]  = |term_v;
                assign out_oe_next[gi*WW + gb] = |term_en;
            end
            assign external_output[gi*WW +: WW] = active_reg[MODE_OUT + gi]
                                                ? out_reg[gi*WW +: WW]
                                                : out_v_next[gi*WW +: WW];
        end
    endgenerate

    assign ext_oe = out_oe_next;

endmodule

// File: tb/tb_io_block_registered.sv
module tb_io_block_registered;

    logic       clk;
    logic       rst;
    logic       cfg_en;
    logic       cfg_in;
    logic       cfg_load;
    logic       cfg_out;
    logic [5:0] track_in;
    logic [5:0] track_out;
    logic [5:0] track_oe;
    logic [5:0] external_input;
    logic [8:0] external_output;
    logic [8:0] ext_oe;
    logic       conflict;

    int tests_run;
    int tests_failed;

    io_block_registered dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_en          (cfg_en),
        .cfg_in          (cfg_in),
        .cfg_load        (cfg_load),
        .cfg_out         (cfg_out),
        .track_in        (track_in),
        .track_out       (track_out),
        .track_oe        (track_oe),
        .external_input  (external_input),
        .external_output (external_output),
        .ext_oe          (ext_oe),
        .conflict        (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_cfg(input logic [34:0] val);
        for (int i = 0; i < 35; i++) begin
            cfg_en = 1'b1;
            cfg_in = val[i];
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic load_cfg();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    logic [34:0] cfg;

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        cfg_en         = 1'b0;
        cfg_in         = 1'b0;
        cfg_load       = 1'b0;
        track_in       = '0;
        external_input = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_track_oe", track_oe, 6'd0);
        check("rst_cfg_out", cfg_out, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_track_oe", track_oe, 6'd0);
        check("post_rst_ext_oe", ext_oe, 9'd0);
        check("post_rst_conflict", conflict, 1'b0);

        // ---------------- chain, registered input port 0 ----------------
        cfg = '0;
        cfg[0]  = 1'b1;
        cfg[30] = 1'b1;
        shift_cfg(cfg);
        check("t2_preload_oe", track_oe, 6'd0);
        load_cfg();
        check("t2_track_oe", track_oe, 6'b000001);
        external_input = 6'b000001;
        #1;
        check("t2_reg_not_yet", track_out, 6'd0);
        tick();
        check("t2_reg_lat1", track_out, 6'b000001);
        external_input = 6'b000000;
        #1;
        check("t2_reg_hold", track_out, 6'b000001);
        tick();
        check("t2_reg_clear", track_out, 6'd0);

        // ---------------- bypass output, track 3 -> port 0 bit 0 ----------------
        cfg = '0;
        cfg[15] = 1'b1;
        shift_cfg(cfg);
        load_cfg();
        check("t3_track_oe", track_oe, 6'd0);
        check("t3_ext_oe", ext_oe, 9'b000000001);
        track_in = 6'b001000;
        #1;
        check("t3_byp_hi", external_output, 9'b000000001);
        track_in = 6'b000000;
        #1;
        check("t3_byp_lo", external_output, 9'd0);
        track_in = 6'b000001;
        #1;
        check("t3_unconnected_track", external_output, 9'd0);
        track_in = 6'b000000;

        // ---------------- registered output ----------------
        cfg[32] = 1'b1;
        shift_cfg(cfg);
        load_cfg();
        tick();
        track_in = 6'b001000;
        #1;
        check("t4_reg_not_yet", external_output, 9'd0);
        tick();
        check("t4_reg_lat1", external_output, 9'b000000001);
        track_in = 6'b000000;
        #1;
        check("t4_reg_hold", external_output, 9'b000000001);
        tick();
        check("t4_reg_clear", external_output, 9'd0);
        check("t4_ext_oe", ext_oe, 9'b000000001);

        // ---------------- conflict ----------------
        cfg = '0;
        cfg[1] = 1'b1;
        cfg[7] = 1'b1;
        shift_cfg(cfg);
        load_cfg();
        check("t5_conflict_at_load", conflict, 1'b0);
        tick();
        check("t5_conflict_set", conflict, 1'b1);
        check("t5_track_oe", track_oe, 6'b000010);
        external_input = 6'b000010;
        #1;
        check("t5_or_in0", track_out, 6'b000010);
        external_input = 6'b010000;
        #1;
        check("t5_or_in1", track_out, 6'b000010);
        external_input = 6'b101101;
        #1;
        check("t5_or_none", track_out, 6'd0);
        external_input = 6'b000000;
        cfg = '0;
        cfg[0] = 1'b1;
        shift_cfg(cfg);
        check("t5_sticky_while_shift", conflict, 1'b1);
        load_cfg();
        check("t5_cleared", conflict, 1'b0);
        tick();
        check("t5_stays_clear", conflict, 1'b0);

        // ---------------- shadow isolation and chain latency ----------------
        external_input = 6'b000001;
        #1;
        check("t6_base_out", track_out, 6'b000001);
        for (int n = 1; n <= 35; n++) begin
            cfg_en = 1'b1;
            cfg_in = (n == 1);
            tick();
            if (n == 20) begin
                check("t6_iso_track_out", track_out, 6'b000001);
                check("t6_iso_track_oe", track_oe, 6'b000001);
            end
            if (n == 34) check("t6_cfg_out_34", cfg_out, 1'b0);
            if (n == 35) check("t6_cfg_out_35", cfg_out, 1'b1);
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;

        // ---------------- async reset mid-shift ----------------
        for (int n = 0; n < 10; n++) begin
            cfg_en = 1'b1;
            cfg_in = 1'b1;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check("t1_async_track_out", track_out, 6'd0);
        check("t1_async_track_oe", track_oe, 6'd0);
        check("t1_async_cfg_out", cfg_out, 1'b0);
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        // One fresh bit must land on an all-zero shadow: only A[34] ends up set.
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        tick();
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        check("t1_resume_cfg_out", cfg_out, 1'b0);
        load_cfg();
        check("t1_resume_track_oe", track_oe, 6'd0);
        check("t1_resume_ext_oe", ext_oe, 9'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
